// File: rtl/sha256_stream_padder.sv
// ---------------------------------------------------------------------------
// sha256_stream_padder
//
// Message front-end for the SHA-256 / HMAC-SHA256 compression cores. Packs a
// byte stream (DATA_BYTES per beat, first byte in the MSBs) into 512-bit
// blocks. It then appends the 0x80 marker, the zero fill and the 64-bit
// big-endian bit length. Blocks leave through a valid/ready handshake.
//
// Ports
//   clk, rst      clock, synchronous active-high reset
//   start         begin a new message (clears all state, drops in-flight block)
//   ready         update/finalize is accepted this cycle when high
//   update        append data_in (bytes_valid bytes, MSB-aligned)
//   data_in       8*DATA_BYTES bits, byte 0 in the MSBs
//   bytes_valid   1..DATA_BYTES valid bytes
//   finalize      end of message (may coincide with the last update)
//   block_valid   block_data holds a block for the sink
//   block_ready   sink accepts the block
//   block_data    512-bit block, byte 0 in bits 511:504
//   block_last    marks the final block of the message
//   err           sticky protocol error, cleared by start or rst
// ---------------------------------------------------------------------------
module sha256_stream_padder #(
    parameter int DATA_BYTES = 4,
    parameter int LEN_BITS   = 64
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    output logic                          ready,
    input  logic                          update,
    input  logic [8*DATA_BYTES-1:0]       data_in,
    input  logic [$clog2(DATA_BYTES):0]   bytes_valid,
    input  logic                          finalize,
    output logic                          block_valid,
    input  logic                          block_ready,
    output logic [511:0]                  block_data,
    output logic                          block_last,
    output logic                          err
);

    localparam int BV_W  = $clog2(DATA_BYTES) + 1;
    localparam int WORDS = 64 / DATA_BYTES;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_ACCEPT  = 3'd1,
        ST_EMIT    = 3'd2,
        ST_FINAL_A = 3'd3,
        ST_FINAL_B = 3'd4
    } state_t;

    state_t                 state_q,    state_d;
    logic [6:0]             ptr_q,      ptr_d;
    logic [LEN_BITS-1:0]    len_q,      len_d;
    logic                   partial_q,  partial_d;
    logic                   fin_pend_q, fin_pend_d;
    logic                   err_q,      err_d;
    logic                   ready_q,    ready_d;
    logic                   valid_q,    valid_d;
    logic                   last_q,     last_d;
    logic [511:0]           buf_q,      buf_d;

    logic [511:0]           buf_n_s;
    logic [6:0]             ptr_n_s;
    logic [LEN_BITS-1:0]    len_n_s;
    logic                   bv_legal_s;
    logic                   upd_ok_s;
    logic                   bad_cmd_s;

    // Every accepted update starts on a DATA_BYTES boundary: only a finalize
    // may follow a short word. So the target word is selected by comparing
    // ptr against each aligned offset, which keeps all part-selects constant.
    function automatic logic [511:0] write_word(
        input logic [511:0]            blk,
        input logic [6:0]              p,
        input logic [8*DATA_BYTES-1:0] d,
        input logic [BV_W-1:0]         n
    );
        logic [511:0] r;
        r = blk;
        for (int w = 0; w < WORDS; w++) begin
            for (int i = 0; i < DATA_BYTES; i++) begin
                r[511-8*(w*DATA_BYTES+i) -: 8] =
                    ((p == 7'(w*DATA_BYTES)) && (BV_W'(i) < n))
                        ? d[8*DATA_BYTES-1-8*i -: 8]
                        : r[511-8*(w*DATA_BYTES+i) -: 8];
            end
        end
        return r;
    endfunction

    // Marker at byte p, zeros after it. If the length still fits
    // (p <= 55), it overwrites bytes 56..63.
    function automatic logic [511:0] pad_block(
        input logic [511:0] blk,
        input logic [6:0]   p,
        input logic [63:0]  l
    );
        logic [511:0] r;
        r = blk;
        for (int k = 0; k < 64; k++) begin
            r[511-8*k -: 8] = (7'(k) == p) ? 8'h80 :
                              ((7'(k) > p) ? 8'h00 : r[511-8*k -: 8]);
        end
        r[63:0] = (p <= 7'd55) ? l : r[63:0];
        return r;
    endfunction

    // Next-state, datapath and output computation.
    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        len_d      = len_q;
        partial_d  = partial_q;
        fin_pend_d = fin_pend_q;
        err_d      = err_q;
        ready_d    = ready_q;
        valid_d    = valid_q;
        last_d     = last_q;
        buf_d      = buf_q;

        buf_n_s    = buf_q;
        ptr_n_s    = ptr_q;
        len_n_s    = len_q;
        bv_legal_s = (bytes_valid != {BV_W{1'b0}}) &&
                     (bytes_valid <= BV_W'(DATA_BYTES));
        upd_ok_s   = update && ready_q && !partial_q && bv_legal_s;
        // Commands with ready low, and malformed updates, are dropped and flagged.
        bad_cmd_s  = ((update || finalize) && !ready_q) ||
                     (update && ready_q && !upd_ok_s);

        if (start) begin
            state_d    = ST_ACCEPT;
            ptr_d      = 7'd0;
            len_d      = {LEN_BITS{1'b0}};
            partial_d  = 1'b0;
            fin_pend_d = 1'b0;
            err_d      = 1'b0;
            ready_d    = 1'b1;
            valid_d    = 1'b0;
            last_d     = 1'b0;
            buf_d      = 512'h0;
        end else begin
            if (bad_cmd_s) begin
                err_d = 1'b1;
            end else begin
                err_d = err_q;
            end

            case (state_q)
                ST_IDLE: begin
                    ready_d = 1'b0;
                end

                ST_ACCEPT: begin
                    if (upd_ok_s) begin
                        buf_n_s = write_word(buf_q, ptr_q, data_in, bytes_valid);
                        ptr_n_s = ptr_q + 7'(bytes_valid);
                        len_n_s = len_q + LEN_BITS'({bytes_valid, 3'b000});
                    end else begin
                        buf_n_s = buf_q;
                        ptr_n_s = ptr_q;
                        len_n_s = len_q;
                    end

                    if (upd_ok_s && (bytes_valid < BV_W'(DATA_BYTES))) begin
                        partial_d = 1'b1;
                    end else begin
                        partial_d = partial_q;
                    end

                    buf_d = buf_n_s;
                    ptr_d = ptr_n_s;
                    len_d = len_n_s;

                    if (ptr_n_s == 7'd64) begin
                        // Full block: emit it and remember a coincident finalize.
                        state_d    = ST_EMIT;
                        ready_d    = 1'b0;
                        valid_d    = 1'b1;
                        last_d     = 1'b0;
                        fin_pend_d = finalize;
                    end else if (ready_q && finalize) begin
                        // Build the pad block directly so it appears one cycle later.
                        state_d = ST_FINAL_A;
                        ready_d = 1'b0;
                        valid_d = 1'b1;
                        last_d  = (ptr_n_s <= 7'd55);
                        buf_d   = pad_block(buf_n_s, ptr_n_s, 64'(len_n_s));
                    end else begin
                        state_d = ST_ACCEPT;
                    end
                end

                ST_EMIT: begin
                    if (valid_q && block_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        ptr_d   = 7'd0;
                        if (fin_pend_q) begin
                            state_d    = ST_FINAL_A;
                            fin_pend_d = 1'b0;
                            ready_d    = 1'b0;
                        end else begin
                            state_d = ST_ACCEPT;
                            ready_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_EMIT;
                    end
                end

                ST_FINAL_A: begin
                    if (!valid_q) begin
                        // Entered from EMIT with an empty buffer: build the pad block now.
                        valid_d = 1'b1;
                        last_d  = (ptr_q <= 7'd55);
                        buf_d   = pad_block(buf_q, ptr_q, 64'(len_q));
                    end else if (block_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        if (last_q) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_FINAL_B;
                        end
                    end else begin
                        state_d = ST_FINAL_A;
                    end
                end

                ST_FINAL_B: begin
                    if (!valid_q) begin
                        valid_d = 1'b1;
                        last_d  = 1'b1;
                        buf_d   = {448'h0, 64'(len_q)};
                    end else if (block_ready) begin
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_FINAL_B;
                    end
                end

                default: begin
                    state_d = ST_IDLE;
                    ready_d = 1'b0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                end
            endcase
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            ptr_q      <= 7'd0;
            len_q      <= {LEN_BITS{1'b0}};
            partial_q  <= 1'b0;
            fin_pend_q <= 1'b0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            buf_q      <= 512'h0;
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            len_q      <= len_d;
            partial_q  <= partial_d;
            fin_pend_q <= fin_pend_d;
            err_q      <= err_d;
            ready_q    <= ready_d;
            valid_q    <= valid_d;
            last_q     <= last_d;
            buf_q      <= buf_d;
        end
    end

    assign ready       = ready_q;
    assign block_valid = valid_q;
    assign block_last  = last_q;
    assign block_data  = buf_q;
    assign err         = err_q;

    sha256_stream_padder_chk u_chk (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .ready       (ready_q),
        .block_valid (valid_q),
        .block_ready (block_ready),
        .block_last  (last_q),
        .block_data  (buf_q)
    );

endmodule

// ---------------------------------------------------------------------------
// sha256_stream_padder_chk
//
// Protocol properties of the padder output interface: ready and block_valid
// are exclusive, and block_last only accompanies a valid block. A stalled
// block keeps its data and last flag until it transfers.
// ---------------------------------------------------------------------------
module sha256_stream_padder_chk (
    input logic         clk,
    input logic         rst,
    input logic         start,
    input logic         ready,
    input logic         block_valid,
    input logic         block_ready,
    input logic         block_last,
    input logic [511:0] block_data
);

    a_ready_excl: assert property (@(posedge clk) disable iff (rst)
        !(ready && block_valid));

    a_last_valid: assert property (@(posedge clk) disable iff (rst)
        block_last |-> block_valid);

    a_hold: assert property (@(posedge clk) disable iff (rst)
        (block_valid && !block_ready && !start) |=>
        (block_valid && $stable(block_data) && $stable(block_last)));

endmodule

// File: tb/tb_sha256_stream_padder.sv
module tb_sha256_stream_padder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        start4, update4, fin4, brdy4;
    logic [31:0] data4;
    logic [2:0]  bv4;
    logic        ready4, bvld4, blast4, err4;
    logic [511:0] bdata4;

    logic        start8, update8, fin8, brdy8;
    logic [63:0] data8;
    logic [3:0]  bv8;
    logic        ready8, bvld8, blast8, err8;
    logic [511:0] bdata8;

    int total = 0;
    int bad   = 0;
    int xfer4 = 0;
    int xfer8 = 0;
    logic [512:0] q4[$];
    logic [512:0] q8[$];
    logic [512:0] e4, e8;

    sha256_stream_padder #(.DATA_BYTES(4), .LEN_BITS(64)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .ready(ready4),
        .update(update4), .data_in(data4), .bytes_valid(bv4),
        .finalize(fin4), .block_valid(bvld4), .block_ready(brdy4),
        .block_data(bdata4), .block_last(blast4), .err(err4)
    );

    sha256_stream_padder #(.DATA_BYTES(8), .LEN_BITS(32)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .ready(ready8),
        .update(update8), .data_in(data8), .bytes_valid(bv8),
        .finalize(fin8), .block_valid(bvld8), .block_ready(brdy8),
        .block_data(bdata8), .block_last(blast8), .err(err8)
    );

    task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 2 time units after the rising edge; monitors sample on the falling edge.
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    // Monitor for the 4-byte instance: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (!rst && bvld4 && brdy4) begin
            xfer4++;
            if (q4.size() == 0) begin
                total++;
                bad++;
                $display("FAIL block4 unexpected: got %0h expected no block", bdata4);
            end else begin
                e4 = q4.pop_front();
                check("block4 data", bdata4, e4[511:0]);
                check("block4 last", 512'(blast4), 512'(e4[512]));
            end
        end
    end

    // Monitor for the 8-byte instance.
    always @(negedge clk) begin
        if (!rst && bvld8 && brdy8) begin
            xfer8++;
            if (q8.size() == 0) begin
                total++;
                bad++;
                $display("FAIL block8 unexpected: got %0h expected no block", bdata8);
            end else begin
                e8 = q8.pop_front();
                check("block8 data", bdata8, e8[511:0]);
                check("block8 last", 512'(blast8), 512'(e8[512]));
            end
        end
    end

    task automatic start4_t();
        start4 = 1'b1;
        step();
        start4 = 1'b0;
    endtask

    task automatic wait_ready4();
        for (int i = 0; i < 50 && !ready4; i++) step();
        check("ready4 wait", 512'(ready4), 512'(1));
    endtask

    task automatic upd4_t(input logic [31:0] d, input logic [2:0] n, input logic f);
        wait_ready4();
        update4 = 1'b1;
        data4   = d;
        bv4     = n;
        fin4    = f;
        step();
        update4 = 1'b0;
        fin4    = 1'b0;
    endtask

    task automatic fin4_t();
        wait_ready4();
        fin4 = 1'b1;
        step();
        fin4 = 1'b0;
    endtask

    task automatic drain4();
        for (int i = 0; i < 100 && q4.size() != 0; i++) step();
        check("drain4", 512'(q4.size()), 512'h0);
    endtask

    task automatic drain8();
        for (int i = 0; i < 100 && q8.size() != 0; i++) step();
        check("drain8", 512'(q8.size()), 512'h0);
    endtask

    function automatic logic [31:0] word(input int j);
        return 32'h00010203 + 32'(j) * 32'h04040404;
    endfunction

    initial begin
        int x;
        rst = 1'b1;
        start4 = 1'b0; update4 = 1'b0; fin4 = 1'b0; brdy4 = 1'b1; data4 = 32'h0; bv4 = 3'd0;
        start8 = 1'b0; update8 = 1'b0; fin8 = 1'b0; brdy8 = 1'b1; data8 = 64'h0; bv8 = 4'd0;
        repeat (3) step();
        rst = 1'b0;

        // Reset state
        check("rst ready",  512'(ready4), 512'(0));
        check("rst valid",  512'(bvld4),  512'(0));
        check("rst last",   512'(blast4), 512'(0));
        check("rst err",    512'(err4),   512'(0));
        check("rst data",   bdata4,       512'h0);
        check("rst valid8", 512'(bvld8),  512'(0));
        step();
        check("idle ready", 512'(ready4), 512'(0));

        // 1: "abc"
        start4_t();
        check("start ready", 512'(ready4), 512'(1));
        upd4_t(32'h61626300, 3'd3, 1'b0);
        q4.push_back({1'b1, 32'h61626380, 448'h0, 32'h00000018});
        fin4_t();
        check("abc latency", 512'(bvld4),  512'(1));
        check("abc last",    512'(blast4), 512'(1));
        check("abc err",     512'(err4),   512'(0));
        drain4();

        // 2: empty message, exactly one transfer
        x = xfer4;
        start4_t();
        q4.push_back({1'b1, 8'h80, 504'h0});
        fin4_t();
        check("empty latency", 512'(bvld4), 512'(1));
        drain4();
        repeat (4) step();
        check("empty one xfer", 512'(xfer4), 512'(x + 1));

        // 3: 56 bytes -> two blocks
        start4_t();
        for (int j = 0; j < 14; j++) upd4_t(word(j), 3'd4, 1'b0);
        q4.push_back({1'b0, 512'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f30313233343536378000000000000000});
        q4.push_back({1'b1, 448'h0, 64'h1c0});
        fin4_t();
        check("56 first last", 512'(blast4), 512'(0));
        drain4();
        for (int i = 0; i < 20 && bvld4; i++) step();

        // 4: 64 bytes with backpressure, finalize on the last update
        brdy4 = 1'b0;
        start4_t();
        q4.push_back({1'b0, 512'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f});
        q4.push_back({1'b1, 8'h80, 440'h0, 64'h200});
        for (int j = 0; j < 15; j++) upd4_t(word(j), 3'd4, 1'b0);
        upd4_t(word(15), 3'd4, 1'b1);
        check("64 latency", 512'(bvld4),  512'(1));
        check("64 last",    512'(blast4), 512'(0));
        for (int i = 0; i < 5; i++) begin
            check("stall valid", 512'(bvld4), 512'(1));
            check("stall ready", 512'(ready4), 512'(0));
            check("stall data",  bdata4, 512'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f);
            step();
        end
        brdy4 = 1'b1;
        drain4();
        for (int i = 0; i < 20 && bvld4; i++) step();

        // 6a: update after a short word, illegal bytes_valid
        start4_t();
        upd4_t(32'h41420000, 3'd2, 1'b0);
        check("short no err", 512'(err4), 512'(0));
        upd4_t(32'h43444546, 3'd4, 1'b0);
        check("after short err", 512'(err4), 512'(1));
        q4.push_back({1'b1, 16'h4142, 8'h80, 424'h0, 64'h10});
        fin4_t();
        check("err sticky", 512'(err4), 512'(1));
        drain4();
        start4_t();
        check("start clears err", 512'(err4), 512'(0));
        upd4_t(32'h11223344, 3'd0, 1'b0);
        check("bv0 err", 512'(err4), 512'(1));
        start4_t();
        upd4_t(32'h11223344, 3'd5, 1'b0);
        check("bv5 err", 512'(err4), 512'(1));
        q4.push_back({1'b1, 8'h80, 504'h0});
        fin4_t();
        drain4();
        for (int i = 0; i < 20 && bvld4; i++) step();
        update4 = 1'b1; data4 = 32'h01020304; bv4 = 3'd4;
        step();
        update4 = 1'b0;
        check("idle update err", 512'(err4), 512'(1));

        // 6b: start during EMIT discards the block
        brdy4 = 1'b0;
        start4_t();
        for (int j = 0; j < 16; j++) upd4_t(word(j), 3'd4, 1'b0);
        check("emit valid", 512'(bvld4), 512'(1));
        step();
        start4_t();
        check("abort valid", 512'(bvld4), 512'(0));
        check("abort err",   512'(err4),  512'(0));
        check("abort ready", 512'(ready4), 512'(1));
        brdy4 = 1'b1;
        q4.push_back({1'b1, 8'h80, 504'h0});
        fin4_t();
        drain4();
        for (int i = 0; i < 20 && bvld4; i++) step();

        // 6c: rst while FINAL_A holds a block
        brdy4 = 1'b0;
        start4_t();
        upd4_t(32'hdeadbeef, 3'd4, 1'b0);
        fin4_t();
        check("final_a valid", 512'(bvld4), 512'(1));
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2 valid", 512'(bvld4),  512'(0));
        check("rst2 ready", 512'(ready4), 512'(0));
        check("rst2 last",  512'(blast4), 512'(0));
        check("rst2 err",   512'(err4),   512'(0));
        check("rst2 data",  bdata4,       512'h0);
        x = xfer4;
        brdy4 = 1'b1;
        repeat (5) step();
        check("no block after rst", 512'(xfer4), 512'(x));

        // 5: DATA_BYTES=8 "Hi There"
        start8 = 1'b1;
        step();
        start8 = 1'b0;
        check("ready8", 512'(ready8), 512'(1));
        q8.push_back({1'b1, 64'h4869205468657265, 8'h80, 376'h0, 64'h40});
        update8 = 1'b1; data8 = 64'h4869205468657265; bv8 = 4'd8; fin8 = 1'b1;
        step();
        update8 = 1'b0; fin8 = 1'b0;
        check("hi latency", 512'(bvld8),  512'(1));
        check("hi last",    512'(blast8), 512'(1));
        check("hi err",     512'(err8),   512'(0));
        drain8();
        repeat (3) step();
        check("hi one xfer", 512'(xfer8), 512'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sha256_stream_padder.md
Name: sha256_stream_padder

Overview:
- Parametrised message front-end for the SHA-256 / HMAC-SHA256 cores.
- Accepts a byte stream DATA_BYTES wide and assembles it into 512-bit blocks.
- Appends the 0x80 marker, zero fill and the 64-bit big-endian bit-length, with a valid/ready handshake to the compression core.
- Replaces the fixed 32-bit word packing inside the streaming hash cores, and adds backpressure, mid-block abort and a protocol-error flag.

Parameters:
DATA_BYTES, 4, input width in bytes; legal values 1, 2, 4, 8.
LEN_BITS, 64, width of the internal bit-length counter; 9 to 64; zero-extended into the 64-bit length field.

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin new message; clears all state
ready  out  1  update/finalize accepted this cycle when high
update  in  1  append data_in
data_in  in  8*DATA_BYTES  first byte in MSBs
bytes_valid  in  $clog2(DATA_BYTES)+1  number of valid bytes, 1..DATA_BYTES, MSB-aligned
finalize  in  1  end of message
block_valid  out  1  block_data holds a block
block_ready  in  1  sink accepts the block
block_data  out  512  block, byte 0 in bits 511:504
block_last  out  1  qualifies the final block of the message
err  out  1  sticky protocol error; cleared by start or rst

Behaviour:
- Reset: state IDLE; ready, block_valid, block_last and err = 0; block_data = 0; byte pointer ptr = 0; length = 0.
- start (any state, highest priority after rst):
  - next cycle: state ACCEPT, ready = 1, block_valid = 0; ptr, length, err and partial flag cleared.
  - an in-flight block is discarded.
- States: IDLE, ACCEPT, EMIT, FINAL_A, FINAL_B.
- ACCEPT, update && ready:
  - bytes_valid bytes written at ptr..ptr+bytes_valid-1;
  - ptr += bytes_valid; length += 8*bytes_valid, wrapping mod 2^LEN_BITS.
  - bytes_valid < DATA_BYTES sets the partial flag.
- ACCEPT, ptr reaches 64:
  - next cycle state EMIT, block_valid = 1, block_last = 0, ready = 0.
- Any update while the partial flag is set: dropped, err set. Only finalize may follow a partial word.
- bytes_valid = 0 or > DATA_BYTES with update: dropped, err set.
- update or finalize while ready = 0: ignored, err set.
- EMIT:
  - block_data and block_last held stable while block_valid && !block_ready.
  - Transfer occurs on the cycle block_valid && block_ready.
  - Next cycle: ptr = 0, block_valid = 0, then:
    - if a finalize is pending, state FINAL_A;
    - otherwise state ACCEPT with ready = 1.
- finalize && ready (ACCEPT):
  - if update is also asserted that cycle, the data is appended first.
  - If the update fills the block, the finalize is latched as pending and ACCEPT → EMIT → FINAL_A.
  - Otherwise next cycle state FINAL_A.
- FINAL_A:
  - byte ptr = 0x80; bytes ptr+1..63 = 0.
  - If ptr ≤ 55: bytes 56..63 = length (zero-extended, big-endian); block_last = 1.
  - Else: block_last = 0.
  - block_valid = 1 until transfer.
  - After transfer: state FINAL_B if the block was not last, else IDLE.
- FINAL_B:
  - block = 56 zero bytes + length; block_last = 1; after transfer state IDLE.
- IDLE: ready = 0 until the next start.
- Latency:
  - last filling update to block_valid = 1 cycle;
  - finalize to final block_valid = 1 cycle, when no full block is outstanding.
- Zero-length message (start then finalize): single block 0x80 followed by zeros, length 0, last = 1.
- rst mid-EMIT: block_valid drops the next cycle; no further blocks.

Test Plan:
1. DATA_BYTES=4: start, update "abc" with bytes_valid=3, finalize → one block 0x61626380, 0…0, last word 0x00000018; block_last=1; err=0.
2. Empty message: start, finalize → block 0x80 then zeros, length field 0; block_last=1; exactly one transfer.
3. 56-byte message (14 full words) → block 1 = data, 0x80, 7 zero bytes, last=0; block 2 = zeros, length 0x1C0, last=1.
4. 64-byte message with block_ready low for 5 cycles:
   - block_valid rises 1 cycle after the 16th update;
   - block_data stable and ready=0 throughout;
   - then a pad block 0x80…, length 0x200, last=1.
5. DATA_BYTES=8: "Hi There" in one update, finalize → block 0x4869205468657265_80…, length 0x40, last=1.
6. Error and abort cases:
   - update after a bytes_valid=2 word → dropped, err=1;
   - start during EMIT → block_valid=0 the next cycle, err=0, ready=1;
   - rst mid-FINAL_A → all outputs 0 the next cycle.
